// File: rtl/lockstep_commit_aligner_pkg.sv
// sodor2_ct_pkg: commit record type plus masked build/compare helpers.
package sodor2_ct_pkg;
    localparam int XLEN = 32;
    localparam int PCSEL_W = 3;
    typedef struct packed {
        logic [XLEN-1:0]    pc_next;
        logic [PCSEL_W-1:0] pc_sel;
        logic               mem_valid;
        logic [XLEN-1:0]    mem_addr;
    } commit_rec_t;
    function automatic commit_rec_t mk_rec(input logic [XLEN-1:0] pc, input logic [PCSEL_W-1:0] sel,
                                           input logic mv, input logic [XLEN-1:0] addr);
        return '{pc_next: pc, pc_sel: sel, mem_valid: mv, mem_addr: mv ? addr : '0};
    endfunction
    function automatic logic rec_eq(input commit_rec_t a, input commit_rec_t b);
        return a.pc_next == b.pc_next && a.pc_sel == b.pc_sel && a.mem_valid == b.mem_valid &&
               (!(a.mem_valid && b.mem_valid) || a.mem_addr == b.mem_addr);
    endfunction
endpackage

// File: rtl/lockstep_commit_aligner_if.sv
// lockstep_commit_aligner_if: two commit streams in, stall/status/counters out.
interface lockstep_commit_aligner_if import sodor2_ct_pkg::*; #(parameter int CNT_W = 32);
    logic               c1_commit, c2_commit;
    logic [XLEN-1:0]    c1_pc_next, c2_pc_next;
    logic [PCSEL_W-1:0] c1_pc_sel, c2_pc_sel;
    logic               c1_mem_valid, c2_mem_valid;
    logic [XLEN-1:0]    c1_mem_addr, c2_mem_addr;
    logic               stall_1, stall_2;
    logic               invalid_program, commit_deviation, addr_deviation;
    logic               finish_1, finish_2, overflow_err, lag_timeout;
    logic [CNT_W-1:0]   total_cycle_cnt, stall_cycle_cnt;
    modport master (
        output c1_commit, c1_pc_next, c1_pc_sel, c1_mem_valid, c1_mem_addr,
        output c2_commit, c2_pc_next, c2_pc_sel, c2_mem_valid, c2_mem_addr,
        input  stall_1, stall_2, invalid_program, commit_deviation, addr_deviation,
        input  finish_1, finish_2, overflow_err, lag_timeout, total_cycle_cnt, stall_cycle_cnt
    );
    modport slave (
        input  c1_commit, c1_pc_next, c1_pc_sel, c1_mem_valid, c1_mem_addr,
        input  c2_commit, c2_pc_next, c2_pc_sel, c2_mem_valid, c2_mem_addr,
        output stall_1, stall_2, invalid_program, commit_deviation, addr_deviation,
        output finish_1, finish_2, overflow_err, lag_timeout, total_cycle_cnt, stall_cycle_cnt
    );
endinterface

// File: rtl/lockstep_commit_aligner_fifo.sv
// ct_rec_fifo: synchronous commit-record FIFO; a push into a full FIFO is dropped.
module ct_rec_fifo import sodor2_ct_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  commit_rec_t   din,
    output commit_rec_t   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    commit_rec_t   mem_q [DEPTH];
    commit_rec_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/lockstep_commit_aligner.sv
// lockstep_commit_aligner: buffers and compares two commit streams, throttles the leading copy.
module lockstep_commit_aligner import sodor2_ct_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32,
    parameter int TIMEOUT = 64,
    parameter int STALL_EN = 1
) (
    input logic clk,
    input logic rst,
    lockstep_commit_aligner_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    commit_rec_t   rec_1, rec_2, head_1, head_2;
    logic          push_1, push_2, pop, full_1, full_2, empty_1, empty_2;
    logic [CW-1:0] cnt_1, cnt_2, nxt_1, nxt_2;
    logic          stall_1_q, stall_1_d, stall_2_q, stall_2_d;
    logic          invalid_q, invalid_d, cdev_q, cdev_d, adev_q, adev_d;
    logic          finish_1_q, finish_1_d, finish_2_q, finish_2_d;
    logic          overflow_q, overflow_d, lag_q, lag_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] total_q, total_d, stall_cnt_q, stall_cnt_d;
    ct_rec_fifo #(.DEPTH(DEPTH)) u_fifo_1 (.clk(clk), .rst(rst), .push(push_1), .pop(pop), .din(rec_1),
        .head(head_1), .count(cnt_1), .full(full_1), .empty(empty_1));
    ct_rec_fifo #(.DEPTH(DEPTH)) u_fifo_2 (.clk(clk), .rst(rst), .push(push_2), .pop(pop), .din(rec_2),
        .head(head_2), .count(cnt_2), .full(full_2), .empty(empty_2));
    always_comb begin
        rec_1 = mk_rec(bus.c1_pc_next, bus.c1_pc_sel, bus.c1_mem_valid, bus.c1_mem_addr);
        rec_2 = mk_rec(bus.c2_pc_next, bus.c2_pc_sel, bus.c2_mem_valid, bus.c2_mem_addr);
        push_1 = bus.c1_commit && !stall_1_q;
        push_2 = bus.c2_commit && !stall_2_q;
        pop = !empty_1 && !empty_2;
        nxt_1 = cnt_1 + CW'(push_1 && !full_1) - CW'(pop);
        nxt_2 = cnt_2 + CW'(push_2 && !full_2) - CW'(pop);
        // Throttle only the copy that is far ahead while the other has nothing queued.
        stall_1_d = STALL_EN != 0 && nxt_1 >= CW'(DEPTH - 1) && cnt_2 == '0;
        stall_2_d = STALL_EN != 0 && nxt_2 >= CW'(DEPTH - 1) && cnt_1 == '0 && !stall_1_d;
        invalid_d = invalid_q || (pop && !rec_eq(head_1, head_2));
        cdev_d = cdev_q || ((bus.c1_commit ^ bus.c2_commit) && !stall_1_q && !stall_2_q);
        adev_d = adev_q || (!cdev_q && rec_1.mem_addr != rec_2.mem_addr);
        finish_1_d = finish_1_q || ((cdev_q || adev_q) && bus.c1_commit);
        finish_2_d = finish_2_q || ((cdev_q || adev_q) && bus.c2_commit);
        overflow_d = overflow_q || (push_1 && full_1) || (push_2 && full_2);
        tmo_d = (empty_1 != empty_2) ? ((tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1)) : '0;
        lag_d = lag_q || tmo_q == TW'(TIMEOUT);
        total_d = (&total_q) ? total_q : total_q + CNT_W'(1);
        stall_cnt_d = ((stall_1_q || stall_2_q) && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_1_q <= 1'b0;
            stall_2_q <= 1'b0;
            invalid_q <= 1'b0;
            cdev_q <= 1'b0;
            adev_q <= 1'b0;
            finish_1_q <= 1'b0;
            finish_2_q <= 1'b0;
            overflow_q <= 1'b0;
            lag_q <= 1'b0;
            tmo_q <= '0;
            total_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_1_q <= stall_1_d;
            stall_2_q <= stall_2_d;
            invalid_q <= invalid_d;
            cdev_q <= cdev_d;
            adev_q <= adev_d;
            finish_1_q <= finish_1_d;
            finish_2_q <= finish_2_d;
            overflow_q <= overflow_d;
            lag_q <= lag_d;
            tmo_q <= tmo_d;
            total_q <= total_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign bus.stall_1 = stall_1_q;
    assign bus.stall_2 = stall_2_q;
    assign bus.invalid_program = invalid_q;
    assign bus.commit_deviation = cdev_q;
    assign bus.addr_deviation = adev_q;
    assign bus.finish_1 = finish_1_q;
    assign bus.finish_2 = finish_2_q;
    assign bus.overflow_err = overflow_q;
    assign bus.lag_timeout = lag_q;
    assign bus.total_cycle_cnt = total_q;
    assign bus.stall_cycle_cnt = stall_cnt_q;
endmodule

// File: tb/tb_lockstep_commit_aligner.sv
// tb_lockstep_commit_aligner: directed scenarios on a stalling and a free-running aligner.
module tb_lockstep_commit_aligner;
    import sodor2_ct_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    lockstep_commit_aligner_if #(.CNT_W(32)) ifa ();
    lockstep_commit_aligner_if #(.CNT_W(32)) ifb ();
    lockstep_commit_aligner #(.STALL_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    lockstep_commit_aligner #(.STALL_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    function automatic logic [8:0] flags_a();
        return {ifa.stall_1, ifa.stall_2, ifa.invalid_program, ifa.commit_deviation, ifa.addr_deviation,
                ifa.finish_1, ifa.finish_2, ifa.overflow_err, ifa.lag_timeout};
    endfunction
    function automatic logic [8:0] flags_b();
        return {ifb.stall_1, ifb.stall_2, ifb.invalid_program, ifb.commit_deviation, ifb.addr_deviation,
                ifb.finish_1, ifb.finish_2, ifb.overflow_err, ifb.lag_timeout};
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drv(input logic k1, input logic [31:0] p1, input logic [2:0] s1, input logic m1, input logic [31:0] a1,
                       input logic k2, input logic [31:0] p2, input logic [2:0] s2, input logic m2, input logic [31:0] a2);
        ifa.c1_commit = k1; ifa.c1_pc_next = p1; ifa.c1_pc_sel = s1; ifa.c1_mem_valid = m1; ifa.c1_mem_addr = a1;
        ifa.c2_commit = k2; ifa.c2_pc_next = p2; ifa.c2_pc_sel = s2; ifa.c2_mem_valid = m2; ifa.c2_mem_addr = a2;
        ifb.c1_commit = k1; ifb.c1_pc_next = p1; ifb.c1_pc_sel = s1; ifb.c1_mem_valid = m1; ifb.c1_mem_addr = a1;
        ifb.c2_commit = k2; ifb.c2_pc_next = p2; ifb.c2_pc_sel = s2; ifb.c2_mem_valid = m2; ifb.c2_mem_addr = a2;
    endtask
    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        n_checks++;
        if (flags_a() !== 9'b0) begin n_fail++; $display("FAIL reset_flags_a: got %b expected 0", flags_a()); end
        n_checks++;
        if (flags_b() !== 9'b0) begin n_fail++; $display("FAIL reset_flags_b: got %b expected 0", flags_b()); end
        n_checks++;
        if (ifa.total_cycle_cnt !== 32'd0 || ifa.stall_cycle_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", ifa.total_cycle_cnt, ifa.stall_cycle_cnt);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (ifa.total_cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL reset_first_count: got %0d expected 1", ifa.total_cycle_cnt); end
    endtask
    task automatic test_identical();
        pulse_rst();
        for (int i = 0; i < 10; i++) begin
            drv(1, 32'h100 + 4 * i, 0, 0, 0, 1, 32'h100 + 4 * i, 0, 0, 0);
            cyc();
        end
        idle();
        cyc();
        cyc();
        n_checks++;
        if (flags_a() !== 9'b0) begin n_fail++; $display("FAIL identical_flags: got %b expected 0", flags_a()); end
        n_checks++;
        if (ifa.total_cycle_cnt !== 32'd12) begin n_fail++; $display("FAIL identical_total: got %0d expected 12", ifa.total_cycle_cnt); end
        n_checks++;
        if (ifa.stall_cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL identical_stall_cnt: got %0d expected 0", ifa.stall_cycle_cnt); end
    endtask
    task automatic test_copy_ahead();
        pulse_rst();
        for (int e = 0; e < 9; e++) begin
            if (e < 3) drv(1, 32'h100 + 4 * e, 0, 0, 0, 0, 0, 0, 0, 0);
            else if (e < 6) drv(0, 0, 0, 0, 0, 1, 32'h100 + 4 * (e - 3), 0, 0, 0);
            else idle();
            cyc();
            if (e == 2) begin
                n_checks++;
                if ({ifa.stall_1, ifa.stall_2, ifa.commit_deviation} !== 3'b101) begin
                    n_fail++; $display("FAIL ahead_stall_on: got %b expected 101", {ifa.stall_1, ifa.stall_2, ifa.commit_deviation});
                end
            end
            if (e == 3) begin
                n_checks++;
                if (ifa.stall_1 !== 1'b1) begin n_fail++; $display("FAIL ahead_stall_hold: got %b expected 1", ifa.stall_1); end
            end
            if (e == 4) begin
                n_checks++;
                if (ifa.stall_1 !== 1'b0) begin n_fail++; $display("FAIL ahead_stall_release: got %b expected 0", ifa.stall_1); end
            end
        end
        n_checks++;
        if (ifa.invalid_program !== 1'b0) begin n_fail++; $display("FAIL ahead_invalid: got %b expected 0", ifa.invalid_program); end
        n_checks++;
        if (ifa.stall_cycle_cnt !== 32'd2) begin n_fail++; $display("FAIL ahead_stall_cnt: got %0d expected 2", ifa.stall_cycle_cnt); end
    endtask
    task automatic test_mismatch();
        pulse_rst();
        for (int k = 0; k < 8; k++) begin
            if (k == 1) drv(1, 32'h104, 0, 0, 32'h11, 1, 32'h104, 0, 0, 32'h22);
            else if (k == 2) drv(1, 32'h108, 0, 1, 32'h40, 1, 32'h108, 0, 1, 32'h40);
            else if (k == 4) drv(1, 32'h110, 1, 0, 0, 1, 32'h110, 2, 0, 0);
            else drv(1, 32'h100 + 4 * k, 0, 0, 0, 1, 32'h100 + 4 * k, 0, 0, 0);
            cyc();
            if (k == 3) begin
                n_checks++;
                if ({ifa.invalid_program, ifa.addr_deviation} !== 2'b00) begin
                    n_fail++; $display("FAIL mismatch_masked_addr: got %b expected 00", {ifa.invalid_program, ifa.addr_deviation});
                end
            end
            if (k == 4) begin
                n_checks++;
                if (ifa.invalid_program !== 1'b0) begin n_fail++; $display("FAIL mismatch_early: got %b expected 0", ifa.invalid_program); end
            end
            if (k == 5) begin
                n_checks++;
                if (ifa.invalid_program !== 1'b1) begin n_fail++; $display("FAIL mismatch_latency: got %b expected 1", ifa.invalid_program); end
            end
        end
        idle();
        cyc();
        n_checks++;
        if (flags_a() !== 9'b001000000) begin n_fail++; $display("FAIL mismatch_final: got %b expected 001000000", flags_a()); end
    endtask
    task automatic test_addr_dev();
        pulse_rst();
        drv(1, 32'h100, 0, 1, 32'h40, 1, 32'h100, 0, 1, 32'h80);
        cyc();
        n_checks++;
        if ({ifa.addr_deviation, ifa.finish_1, ifa.finish_2} !== 3'b100) begin
            n_fail++; $display("FAIL addr_dev_set: got %b expected 100", {ifa.addr_deviation, ifa.finish_1, ifa.finish_2});
        end
        drv(1, 32'h104, 0, 0, 0, 1, 32'h104, 0, 0, 0);
        cyc();
        n_checks++;
        if ({ifa.finish_1, ifa.finish_2} !== 2'b11) begin
            n_fail++; $display("FAIL addr_dev_finish: got %b expected 11", {ifa.finish_1, ifa.finish_2});
        end
        n_checks++;
        if ({ifa.invalid_program, ifa.commit_deviation} !== 2'b10) begin
            n_fail++; $display("FAIL addr_dev_invalid: got %b expected 10", {ifa.invalid_program, ifa.commit_deviation});
        end
        idle();
    endtask
    task automatic test_overflow();
        pulse_rst();
        for (int e = 0; e < 66; e++) begin
            if (e < 5) drv(1, 32'h100 + 4 * e, 0, 0, 0, 0, 0, 0, 0, 0);
            else idle();
            cyc();
            if (e == 3) begin
                n_checks++;
                if ({ifb.overflow_err, ifb.stall_1, ifb.stall_2} !== 3'b000) begin
                    n_fail++; $display("FAIL ovf_before: got %b expected 000", {ifb.overflow_err, ifb.stall_1, ifb.stall_2});
                end
            end
            if (e == 4) begin
                n_checks++;
                if (ifb.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_fifth_push: got %b expected 1", ifb.overflow_err); end
            end
            if (e == 64) begin
                n_checks++;
                if (ifb.lag_timeout !== 1'b0) begin n_fail++; $display("FAIL lag_early: got %b expected 0", ifb.lag_timeout); end
            end
            if (e == 65) begin
                n_checks++;
                if (ifb.lag_timeout !== 1'b1) begin n_fail++; $display("FAIL lag_set: got %b expected 1", ifb.lag_timeout); end
            end
        end
        n_checks++;
        if (ifb.stall_cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL ovf_stall_cnt: got %0d expected 0", ifb.stall_cycle_cnt); end
    endtask
    task automatic test_reset_mid();
        pulse_rst();
        for (int e = 0; e < 3; e++) begin
            drv(1, 32'h200 + 4 * e, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        n_checks++;
        if (ifa.stall_1 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %b expected 1", ifa.stall_1); end
        pulse_rst();
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        n_checks++;
        if (flags_a() !== 9'b0 || ifa.total_cycle_cnt !== 32'd0 || ifa.stall_cycle_cnt !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_clear: got %b/%0d/%0d expected 0/0/0", flags_a(), ifa.total_cycle_cnt, ifa.stall_cycle_cnt);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(1, 32'h300 + 4 * k, 0, 0, 0, 1, 32'h300 + 4 * k, 0, 0, 0);
            cyc();
        end
        idle();
        cyc();
        cyc();
        n_checks++;
        if (flags_a() !== 9'b0) begin n_fail++; $display("FAIL mid_after_flags: got %b expected 0", flags_a()); end
        n_checks++;
        if (ifa.total_cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL mid_after_total: got %0d expected 5", ifa.total_cycle_cnt); end
    endtask
    initial begin
        idle();
        test_reset();
        test_identical();
        test_copy_ahead();
        test_mismatch();
        test_addr_dev();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
